// File: rtl/trap_if.sv
// Purpose: execute-stage exception bus plus CSR-unit trap handshake for trap_unit.
// Latency: n/a (wires only).
// Backpressure: the CSR unit releases a raised trap only by returning flush_ack.
// Ports: master = execute stage / CSR unit side, slave = trap_unit.
interface trap_if;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] instr_word;
  logic [31:0] mem_addr;
  logic        exc_fetch_misal;
  logic        exc_illegal;
  logic        exc_csr_violation;
  logic        exc_ebreak;
  logic        exc_ecall;
  logic        exc_store_misal;
  logic        exc_load_misal;
  logic [1:0]  current_privilege;
  logic        flush_ack;
  logic        trap_sources;
  logic [31:0] trap_instr_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic        stall_pipe;
  logic [31:0] trap_count;
  logic        trap_error;

  modport master (
    output instr_valid, instr_pc, instr_word, mem_addr,
           exc_fetch_misal, exc_illegal, exc_csr_violation, exc_ebreak,
           exc_ecall, exc_store_misal, exc_load_misal, current_privilege,
           flush_ack,
    input  trap_sources, trap_instr_pc, trap_cause, trap_tval,
           stall_pipe, trap_count, trap_error
  );

  modport slave (
    input  instr_valid, instr_pc, instr_word, mem_addr,
           exc_fetch_misal, exc_illegal, exc_csr_violation, exc_ebreak,
           exc_ecall, exc_store_misal, exc_load_misal, current_privilege,
           flush_ack,
    output trap_sources, trap_instr_pc, trap_cause, trap_tval,
           stall_pipe, trap_count, trap_error
  );
endinterface

// File: rtl/trap_unit.sv
// Purpose: pick one synchronous exception by RISC-V priority, latch pc/cause/tval, pulse the CSR unit, stall until flushed.
// Latency: trap_sources and stall_pipe 1 cycle after the hit; ext_irq_sync SYNC_STAGES cycles after ext_irq_async.
// Backpressure: stall_pipe held from RAISE until DRAIN_CYCLES after flush_ack (or ACK_TIMEOUT); exceptions ignored while busy.
// Ports: clk, reset (async, active-high); bus = trap_if.slave; ext_irq_async in, ext_irq_sync out.
module trap_unit #(
  parameter int SYNC_STAGES  = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic clk,
  input  logic reset,
  trap_if.slave bus,
  input  logic ext_irq_async,
  output logic ext_irq_sync
);

  typedef enum logic [1:0] {IDLE, RAISE, WAIT_ACK, DRAIN} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [3:0] DRAIN_INIT   = 4'(DRAIN_CYCLES);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [3:0]  drain_cnt;
  logic        trap_sources_q;
  logic        stall_q;
  logic        trap_error_q;
  logic [31:0] pc_q;
  logic [31:0] cause_q;
  logic [31:0] tval_q;
  logic [31:0] trap_count_q;
  logic [SYNC_STAGES-1:0] irq_sync_q;

  logic        hit;
  logic [31:0] sel_cause;
  logic [31:0] sel_tval;

  assign hit = bus.instr_valid &
               (bus.exc_fetch_misal | bus.exc_illegal | bus.exc_csr_violation |
                bus.exc_ebreak | bus.exc_ecall | bus.exc_store_misal | bus.exc_load_misal);

  // Highest-priority exception wins; store outranks load when both flag.
  always_comb begin
    sel_cause = 32'd0;
    sel_tval  = 32'd0;
    if (bus.exc_fetch_misal) begin
      sel_cause = 32'd0;
      sel_tval  = bus.instr_pc;
    end else if (bus.exc_illegal || bus.exc_csr_violation) begin
      sel_cause = 32'd2;
      sel_tval  = bus.instr_word;
    end else if (bus.exc_ebreak) begin
      sel_cause = 32'd3;
      sel_tval  = bus.instr_pc;
    end else if (bus.exc_ecall) begin
      // Reserved privilege 10 is treated as machine mode.
      case (bus.current_privilege)
        2'b00:   sel_cause = 32'd8;
        2'b01:   sel_cause = 32'd9;
        default: sel_cause = 32'd11;
      endcase
      sel_tval = 32'd0;
    end else if (bus.exc_store_misal) begin
      sel_cause = 32'd6;
      sel_tval  = bus.mem_addr;
    end else if (bus.exc_load_misal) begin
      sel_cause = 32'd4;
      sel_tval  = bus.mem_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      drain_cnt      <= '0;
      trap_sources_q <= 1'b0;
      stall_q        <= 1'b0;
      trap_error_q   <= 1'b0;
      pc_q           <= '0;
      cause_q        <= '0;
      tval_q         <= '0;
      trap_count_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state          <= RAISE;
            trap_sources_q <= 1'b1;
            stall_q        <= 1'b1;
            pc_q           <= bus.instr_pc;
            cause_q        <= sel_cause;
            tval_q         <= sel_tval;
          end
        end
        RAISE: begin
          // An ack already present here belongs to nothing and is not looked at.
          trap_sources_q <= 1'b0;
          if (trap_count_q != 32'hFFFF_FFFF) trap_count_q <= trap_count_q + 32'd1;
          wait_cnt <= '0;
          state    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.flush_ack) begin
            drain_cnt <= DRAIN_INIT;
            state     <= DRAIN;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            trap_error_q <= 1'b1;
            drain_cnt    <= DRAIN_INIT;
            state        <= DRAIN;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 4'd1) begin
            state   <= IDLE;
            stall_q <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Metastability chain for the external interrupt; runs regardless of trap state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_sync_q <= '0;
    else       irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], ext_irq_async};
  end

  assign ext_irq_sync      = irq_sync_q[SYNC_STAGES-1];
  assign bus.trap_sources  = trap_sources_q;
  assign bus.stall_pipe    = stall_q;
  assign bus.trap_instr_pc = pc_q;
  assign bus.trap_cause    = cause_q;
  assign bus.trap_tval     = tval_q;
  assign bus.trap_count    = trap_count_q;
  assign bus.trap_error    = trap_error_q;

endmodule
